// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
//   Polyphonic MIDI voice allocator sitting between the MIDI framer and the
//   voice bank. Each accepted event is scanned against all voices (one voice
//   per cycle), applied in a single cycle, then acknowledged. Note-ons go to
//   a matching voice (retrigger), else the lowest free voice, else the oldest
//   voice is stolen (retrigger). Handles note-off, sustain pedal (CC64),
//   all-notes-off (CC123) and optional channel filtering.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   midi_event_valid              framed event present (held until ack)
//   midi_command                  status byte
//   midi_parameter_1/2            note or controller number / velocity or value
//   midi_event_ack                one-cycle completion pulse
//   voice_gate[NUM_VOICES]        per-voice gate
//   voice_note/voice_velocity     voice i at [7i+6:7i]
//   sustain_pedal                 current pedal state
//   busy                          event in flight (FSM not idle)

package midi_voice_pkg;

    typedef enum logic [1:0] {
        V_FREE,
        V_ON,
        V_HELD,
        V_RETRIG
    } vstate_t;

    // One update broadcast to every voice lane during APPLY.
    typedef struct packed {
        logic       load;          // note-on lands on the selected lane
        logic       retrig;        // load with a gate-low gap
        logic       note_off;      // release lanes whose note matches
        logic       pedal_dn;      // sustain pedal state at note-off time
        logic       release_held;  // pedal lifted: drop HELD lanes
        logic       kill;          // all notes off
        logic [6:0] note;
        logic [6:0] vel;
    } lane_op_t;

endpackage

// midi_voice_lane
//   State, note, velocity, gate, retrigger countdown and age rank of one
//   voice. The countdown runs every cycle regardless of the allocator FSM.
//
// Ports
//   op/sel/bump       broadcast update, this lane is the note-on target,
//                     this lane ages by one
//   state/note/vel/gate/age   current voice state

module midi_voice_lane
    import midi_voice_pkg::*;
#(
    parameter int                AGE_W         = 3,
    parameter int                CNT_W         = 7,
    parameter int                RETRIG_CYCLES = 64,
    parameter logic [AGE_W-1:0]  INIT_AGE      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  lane_op_t         op,
    input  logic             sel,
    input  logic             bump,
    output vstate_t          state,
    output logic [6:0]       note,
    output logic [6:0]       vel,
    output logic             gate,
    output logic [AGE_W-1:0] age
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= V_FREE;
            note  <= '0;
            vel   <= '0;
            gate  <= 1'b0;
            cnt   <= '0;
            age   <= INIT_AGE;
        end else begin
            // Countdown; the event updates below override it for this lane.
            if (state == V_RETRIG) begin
                if (cnt <= CNT_W'(1)) begin
                    cnt   <= '0;
                    gate  <= 1'b1;
                    state <= V_ON;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            if (op.kill) begin
                state <= V_FREE;
                gate  <= 1'b0;
                cnt   <= '0;
            end else if (sel) begin
                note <= op.note;
                vel  <= op.vel;
                if (op.retrig) begin
                    gate  <= 1'b0;
                    cnt   <= CNT_W'(RETRIG_CYCLES);
                    state <= V_RETRIG;
                end else begin
                    gate  <= 1'b1;
                    cnt   <= '0;
                    state <= V_ON;
                end
            end else if (op.note_off && note == op.note &&
                         (state == V_ON || state == V_RETRIG)) begin
                // A pending retrigger is never sustained: it is dropped.
                if (state == V_ON && op.pedal_dn) begin
                    state <= V_HELD;
                end else begin
                    state <= V_FREE;
                    gate  <= 1'b0;
                    cnt   <= '0;
                end
            end else if (op.release_held && state == V_HELD) begin
                state <= V_FREE;
                gate  <= 1'b0;
            end

            if (sel) begin
                age <= '0;
            end else if (bump) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

module midi_voice_allocator
    import midi_voice_pkg::*;
#(
    parameter int NUM_VOICES    = 8,
    parameter int MIDI_CHANNEL  = 0,
    parameter bit OMNI          = 1'b1,
    parameter int RETRIG_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      midi_event_valid,
    input  logic [7:0]                midi_command,
    input  logic [6:0]                midi_parameter_1,
    input  logic [6:0]                midi_parameter_2,
    output logic                      midi_event_ack,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_velocity,
    output logic                      sustain_pedal,
    output logic                      busy
);

    localparam int              IDX_W = $clog2(NUM_VOICES);
    localparam int              CNT_W = $clog2(RETRIG_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        APPLY,
        ACK,
        WAIT_LOW
    } fsm_t;

    fsm_t             fsm;
    logic [7:0]       cmd_q;
    logic [6:0]       p1_q;
    logic [6:0]       p2_q;
    logic [IDX_W-1:0] scan_idx;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;

    vstate_t                          v_state [NUM_VOICES];
    logic [NUM_VOICES-1:0][6:0]       v_note;
    logic [NUM_VOICES-1:0][6:0]       v_vel;
    logic [NUM_VOICES-1:0][IDX_W-1:0] v_age;
    logic [NUM_VOICES-1:0]            v_sel;
    logic [NUM_VOICES-1:0]            v_bump;

    // Event decode and APPLY-cycle broadcast.
    logic             ch_ok;
    logic             apply_en;
    logic             is_on;
    logic             is_off;
    logic             is_sus;
    logic             is_aoff;
    logic             sus_next;
    logic [IDX_W-1:0] tgt_idx;
    logic [IDX_W-1:0] tgt_age;
    lane_op_t         op;

    always_comb begin
        ch_ok    = OMNI || (cmd_q[3:0] == 4'(MIDI_CHANNEL));
        apply_en = (fsm == APPLY) && ch_ok;
        is_on    = (cmd_q[7:4] == 4'h9) && (p2_q != 7'd0);
        is_off   = (cmd_q[7:4] == 4'h8) || ((cmd_q[7:4] == 4'h9) && (p2_q == 7'd0));
        is_sus   = (cmd_q[7:4] == 4'hB) && (p1_q == 7'd64);
        is_aoff  = (cmd_q[7:4] == 4'hB) && (p1_q == 7'd123);
        sus_next = p2_q[6];  // value >= 64

        tgt_idx = match_hit ? match_idx : (free_hit ? free_idx : old_idx);
        tgt_age = v_age[tgt_idx];

        op              = '0;
        op.note         = p1_q;
        op.vel          = p2_q;
        op.load         = apply_en && is_on;
        op.retrig       = match_hit || !free_hit;
        op.note_off     = apply_en && is_off;
        op.pedal_dn     = sustain_pedal;
        op.release_held = apply_en && is_sus && sustain_pedal && !sus_next;
        op.kill         = apply_en && is_aoff;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_lane
            // Target goes to age 0; everything younger than it shifts one older.
            assign v_sel[gi]  = op.load && (tgt_idx == IDX_W'(gi));
            assign v_bump[gi] = op.load && (v_age[gi] < tgt_age);

            midi_voice_lane #(
                .AGE_W         (IDX_W),
                .CNT_W         (CNT_W),
                .RETRIG_CYCLES (RETRIG_CYCLES),
                .INIT_AGE      (IDX_W'(gi))
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .op    (op),
                .sel   (v_sel[gi]),
                .bump  (v_bump[gi]),
                .state (v_state[gi]),
                .note  (v_note[gi]),
                .vel   (v_vel[gi]),
                .gate  (voice_gate[gi]),
                .age   (v_age[gi])
            );

            assign voice_note[7*gi +: 7]     = v_note[gi];
            assign voice_velocity[7*gi +: 7] = v_vel[gi];
        end
    endgenerate

    // Voice under inspection during SCAN.
    vstate_t          s_state;
    logic [6:0]       s_note;
    logic [IDX_W-1:0] s_age;

    always_comb begin
        s_state = v_state[scan_idx];
        s_note  = v_note[scan_idx];
        s_age   = v_age[scan_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= IDLE;
            cmd_q          <= '0;
            p1_q           <= '0;
            p2_q           <= '0;
            scan_idx       <= '0;
            match_hit      <= 1'b0;
            match_idx      <= '0;
            free_hit       <= 1'b0;
            free_idx       <= '0;
            old_idx        <= '0;
            sustain_pedal  <= 1'b0;
            midi_event_ack <= 1'b0;
            busy           <= 1'b0;
        end else begin
            midi_event_ack <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (midi_event_valid) begin
                        cmd_q     <= midi_command;
                        p1_q      <= midi_parameter_1;
                        p2_q      <= midi_parameter_2;
                        scan_idx  <= '0;
                        match_hit <= 1'b0;
                        free_hit  <= 1'b0;
                        old_idx   <= '0;
                        busy      <= 1'b1;
                        fsm       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_hit && s_state != V_FREE && s_note == p1_q) begin
                        match_hit <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (!free_hit && s_state == V_FREE) begin
                        free_hit <= 1'b1;
                        free_idx <= scan_idx;
                    end
                    if (s_age == LAST) begin
                        old_idx <= scan_idx;
                    end
                    if (scan_idx == LAST) begin
                        fsm <= APPLY;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                APPLY: begin
                    if (apply_en && is_sus) begin
                        sustain_pedal <= sus_next;
                    end
                    midi_event_ack <= 1'b1;
                    fsm            <= ACK;
                end
                ACK: begin
                    fsm <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // Framer still holding the same event: do not take it twice.
                    if (!midi_event_valid) begin
                        busy <= 1'b0;
                        fsm  <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator.
//   dut_a: 4 voices, omni, 4-cycle retrigger gap (main vector table)
//   dut_b: 4 voices, channel 2 only (channel filter, reset mid-scan)
//   dut_c: 4 voices, omni, 16-cycle gap (note-off cancelling a retrigger)
// All three share the event inputs; dut_a and dut_c share a reset.

module tb_midi_voice_allocator;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        valid;
    logic [7:0]  cmd;
    logic [6:0]  p1;
    logic [6:0]  p2;

    logic        ack_a, ack_b, ack_c;
    logic [3:0]  gate_a, gate_b, gate_c;
    logic [27:0] note_a, note_b, note_c;
    logic [27:0] vel_a, vel_b, vel_c;
    logic        ped_a, ped_b, ped_c;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(0), .OMNI(1'b1), .RETRIG_CYCLES(R)) dut_a (
        .clk(clk), .rst(rst_a), .midi_event_valid(valid), .midi_command(cmd),
        .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack_a),
        .voice_gate(gate_a), .voice_note(note_a), .voice_velocity(vel_a),
        .sustain_pedal(ped_a), .busy(busy_a));

    midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(2), .OMNI(1'b0), .RETRIG_CYCLES(R)) dut_b (
        .clk(clk), .rst(rst_b), .midi_event_valid(valid), .midi_command(cmd),
        .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack_b),
        .voice_gate(gate_b), .voice_note(note_b), .voice_velocity(vel_b),
        .sustain_pedal(ped_b), .busy(busy_b));

    midi_voice_allocator #(.NUM_VOICES(N), .MIDI_CHANNEL(0), .OMNI(1'b1), .RETRIG_CYCLES(16)) dut_c (
        .clk(clk), .rst(rst_a), .midi_event_valid(valid), .midi_command(cmd),
        .midi_parameter_1(p1), .midi_parameter_2(p2), .midi_event_ack(ack_c),
        .voice_gate(gate_c), .voice_note(note_c), .voice_velocity(vel_c),
        .sustain_pedal(ped_c), .busy(busy_c));

    typedef struct {
        logic [7:0]  cmd;
        logic [6:0]  p1;
        logic [6:0]  p2;
        logic [3:0]  gate;   // settled gates
        logic [3:0]  gap;    // voices held low for R cycles after APPLY
        logic [27:0] note;
        logic [27:0] vel;
        logic        pedal;
    } vec_t;

    vec_t tbl[22];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [27:0] pk(input logic [6:0] v3, input logic [6:0] v2,
                                       input logic [6:0] v1, input logic [6:0] v0);
        return {v3, v2, v1, v0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 1) ? busy_b : busy_a;
    endfunction

    function automatic logic get_ack(input int w);
        return (w == 1) ? ack_b : ack_a;
    endfunction

    // Present one event, return #1 after the APPLY edge with valid dropped.
    task automatic send(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b,
                        input int w, output int lat);
        int n;
        n = 0;
        while (get_busy(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_send", 32'(get_busy(w)), 32'd0);
        @(negedge clk);
        valid = 1'b1; cmd = c; p1 = a; p2 = b;
        @(posedge clk);
        #1 chk("busy_after_accept", 32'(get_busy(w)), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!get_ack(w) && lat < 40);
        valid = 1'b0;
        chk("ack_latency", 32'(lat), 32'(N + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [3:0] eg;

        valid = 1'b0; cmd = '0; p1 = '0; p2 = '0;
        rst_a = 1'b1; rst_b = 1'b1;

        //          cmd    p1     p2     gate     gap      notes {v3,v2,v1,v0}                 velocities                          pedal
        tbl[0]  = '{8'h90, 7'h3C, 7'h64, 4'b0001, 4'b0000, pk(7'h00,7'h00,7'h00,7'h3C), pk(7'h00,7'h00,7'h00,7'h64), 1'b0};
        tbl[1]  = '{8'h90, 7'h3E, 7'h50, 4'b0011, 4'b0000, pk(7'h00,7'h00,7'h3E,7'h3C), pk(7'h00,7'h00,7'h50,7'h64), 1'b0};
        tbl[2]  = '{8'h90, 7'h40, 7'h40, 4'b0111, 4'b0000, pk(7'h00,7'h40,7'h3E,7'h3C), pk(7'h00,7'h40,7'h50,7'h64), 1'b0};
        tbl[3]  = '{8'h90, 7'h41, 7'h30, 4'b1111, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b0};
        tbl[4]  = '{8'h90, 7'h43, 7'h20, 4'b1111, 4'b0001, pk(7'h41,7'h40,7'h3E,7'h43), pk(7'h30,7'h40,7'h50,7'h20), 1'b0};
        tbl[5]  = '{8'h90, 7'h3E, 7'h50, 4'b1111, 4'b0010, pk(7'h41,7'h40,7'h3E,7'h43), pk(7'h30,7'h40,7'h50,7'h20), 1'b0};
        tbl[6]  = '{8'h90, 7'h48, 7'h10, 4'b1111, 4'b0100, pk(7'h41,7'h48,7'h3E,7'h43), pk(7'h30,7'h10,7'h50,7'h20), 1'b0};
        tbl[7]  = '{8'h80, 7'h43, 7'h00, 4'b1110, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h43), pk(7'h30,7'h10,7'h50,7'h20), 1'b0};
        tbl[8]  = '{8'hB0, 7'h7B, 7'h00, 4'b0000, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h43), pk(7'h30,7'h10,7'h50,7'h20), 1'b0};
        tbl[9]  = '{8'h90, 7'h3C, 7'h64, 4'b0001, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b0};
        tbl[10] = '{8'hB0, 7'h40, 7'h7F, 4'b0001, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b1};
        tbl[11] = '{8'h80, 7'h3C, 7'h00, 4'b0001, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b1};
        tbl[12] = '{8'h90, 7'h3E, 7'h50, 4'b0011, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b1};
        tbl[13] = '{8'hB0, 7'h40, 7'h00, 4'b0010, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b0};
        tbl[14] = '{8'h90, 7'h3E, 7'h00, 4'b0000, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b0};
        tbl[15] = '{8'h90, 7'h3C, 7'h64, 4'b0001, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b0};
        tbl[16] = '{8'h90, 7'h3E, 7'h50, 4'b0011, 4'b0000, pk(7'h41,7'h48,7'h3E,7'h3C), pk(7'h30,7'h10,7'h50,7'h64), 1'b0};
        tbl[17] = '{8'h90, 7'h40, 7'h40, 4'b0111, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b0};
        tbl[18] = '{8'hB0, 7'h7B, 7'h00, 4'b0000, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b0};
        tbl[19] = '{8'hC0, 7'h05, 7'h00, 4'b0000, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b0};
        tbl[20] = '{8'hB0, 7'h40, 7'h40, 4'b0000, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b1};
        tbl[21] = '{8'hB0, 7'h40, 7'h3F, 4'b0000, 4'b0000, pk(7'h41,7'h40,7'h3E,7'h3C), pk(7'h30,7'h40,7'h50,7'h64), 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gate", 32'(gate_a), 32'd0);
        chk("rst_note", 32'(note_a), 32'd0);
        chk("rst_vel",  32'(vel_a),  32'd0);
        chk("rst_ack",  32'(ack_a),  32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ped",  32'(ped_a),  32'd0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Vector table on dut_a; gates sampled every cycle through the gap.
        for (int i = 0; i < 22; i++) begin
            send(tbl[i].cmd, tbl[i].p1, tbl[i].p2, 0, lat);
            for (int k = 0; k <= R; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                eg = tbl[i].gate & ~((k < R) ? tbl[i].gap : 4'b0000);
                chk($sformatf("v%0d_gate_c%0d", i, k), 32'(gate_a), 32'(eg));
                if (k == 1) chk($sformatf("v%0d_ack_low", i), 32'(ack_a), 32'd0);
            end
            chk($sformatf("v%0d_note", i),  32'(note_a), 32'(tbl[i].note));
            chk($sformatf("v%0d_vel", i),   32'(vel_a),  32'(tbl[i].vel));
            chk($sformatf("v%0d_pedal", i), 32'(ped_a),  32'(tbl[i].pedal));
            chk($sformatf("v%0d_busy", i),  32'(busy_a), 32'd0);
        end

        // Note-off during a pending retrigger (dut_c, long gap), pedal down.
        @(negedge clk); rst_a = 1'b1;
        #1;
        chk("midrst_gate", 32'(gate_a), 32'd0);
        chk("midrst_note", 32'(note_a), 32'd0);
        @(negedge clk); rst_a = 1'b0;
        send(8'h90, 7'h3C, 7'h64, 0, lat);
        send(8'h90, 7'h3E, 7'h50, 0, lat);
        send(8'h90, 7'h40, 7'h40, 0, lat);
        send(8'h90, 7'h41, 7'h30, 0, lat);
        send(8'hB0, 7'h40, 7'h7F, 0, lat);
        send(8'h90, 7'h43, 7'h20, 0, lat);
        chk("steal_gate_a", 32'(gate_a), 32'b1110);
        chk("steal_gate_c", 32'(gate_c), 32'b1110);
        send(8'h80, 7'h43, 7'h00, 0, lat);
        chk("off_held_gate_a", 32'(gate_a), 32'b1111);
        chk("off_retrig_gate_c", 32'(gate_c), 32'b1110);
        repeat (12) @(posedge clk);
        #1;
        chk("no_late_rise_c", 32'(gate_c), 32'b1110);
        chk("held_still_a", 32'(gate_a), 32'b1111);
        send(8'hB0, 7'h40, 7'h00, 0, lat);
        chk("pedal_up_gate_a", 32'(gate_a), 32'b1110);
        chk("pedal_up_gate_c", 32'(gate_c), 32'b1110);
        chk("pedal_up_ped_a", 32'(ped_a), 32'd0);

        // Channel filter and reset mid-scan (dut_b, channel 2 only).
        repeat (4) @(posedge clk);
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0;
        send(8'h93, 7'h3C, 7'h64, 1, lat);
        chk("ch3_gate", 32'(gate_b), 32'd0);
        chk("ch3_note", 32'(note_b), 32'd0);
        send(8'h92, 7'h40, 7'h40, 1, lat);
        chk("ch2_gate", 32'(gate_b), 32'b0001);
        chk("ch2_note", 32'(note_b), 32'(pk(7'h00, 7'h00, 7'h00, 7'h40)));
        repeat (4) @(negedge clk);
        valid = 1'b1; cmd = 8'h92; p1 = 7'h3C; p2 = 7'h64;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("scan_busy_b", 32'(busy_b), 32'd1);
        rst_b = 1'b1;
        #1;
        chk("scanrst_gate", 32'(gate_b), 32'd0);
        chk("scanrst_note", 32'(note_b), 32'd0);
        chk("scanrst_vel",  32'(vel_b),  32'd0);
        chk("scanrst_busy", 32'(busy_b), 32'd0);
        chk("scanrst_ack",  32'(ack_b),  32'd0);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_b = 1'b0;
        send(8'h92, 7'h3C, 7'h64, 1, lat);
        chk("fresh_gate", 32'(gate_b), 32'b0001);
        chk("fresh_note", 32'(note_b), 32'(pk(7'h00, 7'h00, 7'h00, 7'h3C)));
        chk("fresh_vel",  32'(vel_b),  32'(pk(7'h00, 7'h00, 7'h00, 7'h64)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
